uart_rx_fifo: RTL and testbench

Parametrised UART receiver with a first-word-fall-through receive FIFO. It sits between the board `uart_rx` pin and the CPU I/O read path. It generalises the fixed 8N1 receiver with configurable bit period, data width, parity and stop bits, and adds error detection and buffering of several bytes. The CPU pops bytes with a one-cycle read strobe and can observe and clear sticky error flags.

---
 rtl/uart_rx_fifo.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// UART receiver with a first-word-fall-through receive FIFO. Frames are
// start + DATA_BITS (LSB first) + optional parity + STOP_BITS stop bits.
// Good frames are pushed into a small circular buffer; bad frames only set a
// sticky error flag.
//
// Parameters:
//   WAIT        clock cycles per UART bit (even, >= 4)
//   DATA_BITS   data bits per frame (5..8)
//   PARITY      0 = none, 1 = odd, 2 = even
//   STOP_BITS   1 or 2
//   FIFO_DEPTH  FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-high reset
//   uart_rx     asynchronous serial line, idles high
//   rd_en       pop strobe
//   r_data      FIFO head entry (valid when r_valid = 1)
//   r_valid     FIFO not empty
//   count       number of entries held
//   overrun     sticky: good frame arrived while the FIFO was full
//   frame_err   sticky: a stop bit was sampled low
//   parity_err  sticky: parity mismatch
//   clr_err     clears the three sticky flags (a same-cycle set wins)
//   dbg_state   current receiver FSM state (state_t encoding)
//
// Read handshake: r_valid is the FIFO's "valid", rd_en is the consumer's
// "ready". A pop happens on any clock edge where rd_en & r_valid; rd_en while
// r_valid = 0 has no effect. r_data must be taken before or on that edge.
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int WAIT       = 8,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              uart_rx,
    input  logic                              rd_en,
    output logic [DATA_BITS-1:0]              r_data,
    output logic                              r_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              overrun,
    output logic                              frame_err,
    output logic                              parity_err,
    input  logic                              clr_err,
    output logic [2:0]                        dbg_state
);

    localparam int CNT_W = $clog2(WAIT);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(WAIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(WAIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY_S = 3'd3,
        STOP     = 3'd4
    } state_t;

    state_t state, state_n;

    // Synchroniser plus delayed copy for falling-edge detection.
    logic rx_s1, rx_s2, rx_d;
    logic rx_fall;

    // Bit timing and frame collection.
    logic [CNT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic                 stop_bad;
    logic                 par_bad;
    logic [DATA_BITS-1:0] shreg;

    // FSM strobes.
    logic tick;
    logic load_half, load_full;
    logic shift_en, par_en, stop_en, frame_end;

    // Frame outcome and FIFO control.
    logic stop_low, good, full, push, pop;
    logic set_ovr, set_ferr, set_perr;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;

    // -------------------------------------------------------------------------
    // Synchroniser
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign rx_fall = rx_d & ~rx_s2;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    assign dbg_state = state;

    // -------------------------------------------------------------------------
    // FSM next state and strobes
    // -------------------------------------------------------------------------
    // bit_cnt counts down to the next sample point; a sample is taken on the
    // edge where it has reached zero.
    assign tick = (bit_cnt == '0);

    always_comb begin
        state_n   = state;
        load_half = 1'b0;
        load_full = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        stop_en   = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                if (rx_fall) begin
                    state_n   = START;
                    load_half = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_s2) begin
                        state_n   = DATA;
                        load_full = 1'b1;
                    end else begin
                        // Start bit gone by mid-bit: treat as a line glitch.
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en  = 1'b1;
                    load_full = 1'b1;
                    if (bit_idx == LAST_BIT)
                        state_n = (PARITY != 0) ? PARITY_S : STOP;
                end
            end
            PARITY_S: begin
                if (tick) begin
                    par_en    = 1'b1;
                    load_full = 1'b1;
                    state_n   = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    stop_en = 1'b1;
                    if (stop_idx == LAST_STOP) begin
                        // Leave mid-stop-bit so the next start edge is caught.
                        frame_end = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        load_full = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Bit timing, shift register and per-frame error capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            stop_bad <= 1'b0;
            par_bad  <= 1'b0;
            shreg    <= '0;
        end else begin
            if (load_half)          bit_cnt <= HALF_LOAD;
            else if (load_full)     bit_cnt <= FULL_LOAD;
            else if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;

            if (load_half) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                stop_bad <= 1'b0;
                par_bad  <= 1'b0;
            end else begin
                if (shift_en) begin
                    shreg   <= {rx_s2, shreg[DATA_BITS-1:1]};
                    bit_idx <= bit_idx + 1'b1;
                end
                // Odd parity wants XOR(data, parity) = 1, even wants 0.
                if (par_en)
                    par_bad <= (((^shreg) ^ rx_s2) != (PARITY == 1));
                if (stop_en) begin
                    stop_idx <= stop_idx + 1'b1;
                    if (!rx_s2) stop_bad <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame outcome: frame error beats parity error beats overrun
    // -------------------------------------------------------------------------
    assign stop_low = stop_bad | ~rx_s2;
    assign set_ferr = frame_end & stop_low;
    assign set_perr = frame_end & ~stop_low & par_bad;
    assign good     = frame_end & ~stop_low & ~par_bad;

    assign full     = (count == DEPTH_C);
    assign r_valid  = (count != '0);
    assign pop      = rd_en & r_valid;
    // A pop on the same edge frees the slot being written.
    assign push     = good & (~full | pop);
    assign set_ovr  = good & full & ~pop;

    // -------------------------------------------------------------------------
    // FIFO storage and pointers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign r_data = mem[rd_ptr];

    // -------------------------------------------------------------------------
    // Sticky error flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (set_ovr)      overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;

            if (set_ferr)     frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;

            if (set_perr)     parity_err <= 1'b1;
            else if (clr_err) parity_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed bench for uart_rx_fifo. Three instances share clk/reset:
//   u_a : 8N1, WAIT=8, FIFO_DEPTH=4
//   u_e : 8E1 (even parity)
//   u_s : 8N2 (two stop bits)
// Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int WAIT = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       rx_a = 1'b1, rd_a = 1'b0, clr_a = 1'b0;
  logic       rx_e = 1'b1, rd_e = 1'b0, clr_e = 1'b0;
  logic       rx_s = 1'b1, rd_s = 1'b0, clr_s = 1'b0;

  logic [7:0] a_data, e_data, s_data;
  logic       a_valid, e_valid, s_valid;
  logic [2:0] a_count, e_count, s_count;
  logic       a_ovr, e_ovr, s_ovr;
  logic       a_ferr, e_ferr, s_ferr;
  logic       a_perr, e_perr, s_perr;
  logic [2:0] a_state, e_state, s_state;

  uart_rx_fifo #(.WAIT(WAIT), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .uart_rx(rx_a), .rd_en(rd_a),
    .r_data(a_data), .r_valid(a_valid), .count(a_count),
    .overrun(a_ovr), .frame_err(a_ferr), .parity_err(a_perr),
    .clr_err(clr_a), .dbg_state(a_state)
  );

  uart_rx_fifo #(.WAIT(WAIT), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
    .clk(clk), .reset(reset), .uart_rx(rx_e), .rd_en(rd_e),
    .r_data(e_data), .r_valid(e_valid), .count(e_count),
    .overrun(e_ovr), .frame_err(e_ferr), .parity_err(e_perr),
    .clr_err(clr_e), .dbg_state(e_state)
  );

  uart_rx_fifo #(.WAIT(WAIT), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_s (
    .clk(clk), .reset(reset), .uart_rx(rx_s), .rd_en(rd_s),
    .r_data(s_data), .r_valid(s_valid), .count(s_count),
    .overrun(s_ovr), .frame_err(s_ferr), .parity_err(s_perr),
    .clr_err(clr_s), .dbg_state(s_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (which: 0 = u_a, 1 = u_e, 2 = u_s)
  // ---------------------------------------------------------------------------
  task automatic set_line(input int which, input logic v);
    case (which)
      0:       rx_a = v;
      1:       rx_e = v;
      default: rx_s = v;
    endcase
  endtask

  // Each bit is held for WAIT cycles; called and returns on a falling edge.
  task automatic send_bits(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(which, bits[i]);
      repeat (WAIT) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input logic par_en,
                            input logic par_bit, input int nstop, input logic [1:0] stop_vals);
    logic [15:0] frm;
    int idx;
    frm = '1;
    frm[0] = 1'b0;
    frm[8:1] = data;
    idx = 9;
    if (par_en) begin
      frm[9] = par_bit;
      idx = 10;
    end
    for (int s = 0; s < nstop; s++) frm[idx + s] = stop_vals[s];
    send_bits(which, frm, idx + nstop);
    set_line(which, 1'b1);
  endtask

  task automatic send_good(input int which, input logic [7:0] data);
    send_frame(which, data, (which == 1), ^data, (which == 2) ? 2 : 1, 2'b11);
  endtask

  task automatic pulse_rd_a();
    rd_a = 1'b1;
    @(negedge clk);
    rd_a = 1'b0;
  endtask

  task automatic drain_a(input string tag);
    while (exp_q.size() > 0) begin
      chk(tag, a_data, exp_q.pop_front());
      pulse_rd_a();
    end
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] frm;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_valid", a_valid, 0);
    chk("rst_count", a_count, 0);
    chk("rst_data", a_data, 0);
    chk("rst_flags", {a_ovr, a_ferr, a_perr}, 0);
    chk("rst_state", a_state, 0);
    reset = 1'b0;

    // 8N1 frame 0x0F starting at 2000 ns; result exactly at E2+76
    while ($time < 2000) @(negedge clk);
    frm = '1;
    frm[0] = 1'b0;
    frm[8:1] = 8'h0F;
    send_bits(0, frm, 9);
    set_line(0, 1'b1);
    repeat (6) @(negedge clk);
    chk("t1_valid_before", a_valid, 0);
    @(negedge clk);
    chk("t1_valid", a_valid, 1);
    chk("t1_count", a_count, 1);
    chk("t1_data", a_data, 8'h0F);
    chk("t1_flags", {a_ovr, a_ferr, a_perr}, 0);
    @(negedge clk);
    pulse_rd_a();
    chk("t1_pop_valid", a_valid, 0);
    chk("t1_pop_count", a_count, 0);

    // Five back-to-back frames into a 4-deep FIFO
    for (int d = 1; d <= 4; d++) begin
      send_good(0, d[7:0]);
      exp_q.push_back(d[7:0]);
    end
    chk("t2_count4", a_count, 4);
    chk("t2_no_ovr_yet", a_ovr, 0);
    send_good(0, 8'h05);
    chk("t2_count_full", a_count, 4);
    chk("t2_overrun", a_ovr, 1);
    chk("t2_other_flags", {a_ferr, a_perr}, 0);
    drain_a("t2_pop_data");
    chk("t2_empty_valid", a_valid, 0);
    chk("t2_empty_count", a_count, 0);
    chk("t2_ovr_sticky", a_ovr, 1);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("t2_ovr_cleared", a_ovr, 0);

    // Even parity
    send_frame(1, 8'h03, 1'b1, 1'b0, 1, 2'b11);
    chk("t3_good_count", e_count, 1);
    chk("t3_good_data", e_data, 8'h03);
    chk("t3_good_perr", e_perr, 0);
    send_frame(1, 8'h03, 1'b1, 1'b1, 1, 2'b11);
    chk("t3_bad_perr", e_perr, 1);
    chk("t3_bad_count", e_count, 1);
    chk("t3_bad_ferr", e_ferr, 0);

    // Two stop bits, second one low
    send_frame(2, 8'hA5, 1'b0, 1'b0, 2, 2'b01);
    chk("t4_ferr", s_ferr, 1);
    chk("t4_ferr_count", s_count, 0);
    chk("t4_ferr_perr", s_perr, 0);
    repeat (2 * WAIT) @(negedge clk);
    send_good(2, 8'h5A);
    chk("t4_good_count", s_count, 1);
    chk("t4_good_data", s_data, 8'h5A);
    chk("t4_ferr_sticky", s_ferr, 1);

    // Start glitch: two cycles low
    rx_a = 1'b0;
    repeat (2) @(negedge clk);
    rx_a = 1'b1;
    @(negedge clk);
    chk("t5_in_start", a_state, 1);
    repeat (8) @(negedge clk);
    chk("t5_back_idle", a_state, 0);
    chk("t5_no_push", a_count, 0);
    chk("t5_no_flags", {a_ovr, a_ferr, a_perr}, 0);

    // Reset in the middle of frame 0x77
    send_good(0, 8'h33);
    chk("t5_pre_rst_count", a_count, 1);
    frm = '1;
    frm[0] = 1'b0;
    frm[8:1] = 8'h77;
    send_bits(0, frm, 5);
    reset = 1'b1;
    rx_a = 1'b1;
    #1;
    chk("t5_rst_count", a_count, 0);
    chk("t5_rst_valid", a_valid, 0);
    chk("t5_rst_data", a_data, 0);
    chk("t5_rst_state", a_state, 0);
    chk("t5_rst_s_flags", {s_ovr, s_ferr, s_perr}, 0);
    chk("t5_rst_e_flags", {e_ovr, e_ferr, e_perr}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * WAIT) @(negedge clk);
    chk("t5_after_rst_count", a_count, 0);
    send_good(0, 8'h11);
    chk("t5_after_count", a_count, 1);
    chk("t5_after_data", a_data, 8'h11);
    chk("t5_after_flags", {a_ovr, a_ferr, a_perr}, 0);
    exp_q.push_back(8'h11);
    drain_a("t5_pop_data");

    // Full FIFO, frame completes on the same edge as a pop
    for (int d = 0; d < 4; d++) begin
      send_good(0, 8'hA0 + d[7:0]);
      exp_q.push_back(8'hA0 + d[7:0]);
    end
    chk("t6_full", a_count, 4);
    frm = '1;
    frm[0] = 1'b0;
    frm[8:1] = 8'hA4;
    send_bits(0, frm, 9);
    set_line(0, 1'b1);
    repeat (6) @(negedge clk);
    chk("t6_head_before", a_data, 8'hA0);
    rd_a = 1'b1;
    @(negedge clk);
    rd_a = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'hA4);
    chk("t6_count_same", a_count, 4);
    chk("t6_no_overrun", a_ovr, 0);
    chk("t6_head_after", a_data, 8'hA1);
    @(negedge clk);
    drain_a("t6_pop_data");
    chk("t6_empty", a_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
